q2a_mux: RTL and testbench

4:1 single-bit multiplexer with a registered sample-and-statistics stage. A 2-bit select picks one bit of a 4-bit input vector onto a zero-latency combinational output. A clocked side path captures the selected bit on request and keeps saturating counts of total samples and of samples that were 1. The block is a leaf datapath primitive, used wherever a run-time bit pick plus lightweight observability is needed.

---
 rtl/q2a_mux.sv | 94 +++++++++
 tb/tb_q2a_mux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/q2a_mux.sv
// q2a_mux: 4:1 single-bit multiplexer with a registered capture stage.
// The combinational pick Y is always live, including while reset is held.
// The clocked side path records the last captured bit and its select value.
// It also keeps two saturating counters: all captures, and captures where Y=1.
module q2a_mux #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       number,
  input  logic [1:0]       selection,
  output logic             Y,
  input  logic             en,
  input  logic             clr,
  output logic             y_q,
  output logic [1:0]       sel_q,
  output logic             y_vld,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_ones
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // One-hot AND-OR pick.
  // A deselected channel is gated to 0, so an unknown value on an
  // unselected bit never reaches Y.
  logic [3:0] chan_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      assign chan_hit[gi] = number[gi] & (selection == 2'(gi));
    end
  endgenerate

  assign Y = |chan_hit;

  logic             y_reg, y_next;
  logic [1:0]       sel_reg, sel_next;
  logic             vld_reg, vld_next;
  logic [CNT_W-1:0] total_reg, total_next;
  logic [CNT_W-1:0] ones_reg, ones_next;

  // Next-state for the capture registers and counters.
  // clr wins over a same-cycle increment, but the capture itself still lands.
  // cnt_ones only moves on a counted capture, so it can never exceed cnt_total.
  always_comb begin
    y_next     = y_reg;
    sel_next   = sel_reg;
    vld_next   = en;
    total_next = total_reg;
    ones_next  = ones_reg;
    if (en) begin
      y_next   = Y;
      sel_next = selection;
    end
    if (clr) begin
      total_next = '0;
      ones_next  = '0;
    end else if (en) begin
      if (total_reg != CNT_MAX) begin
        total_next = total_reg + 1'b1;
      end
      if (Y && (ones_reg != CNT_MAX)) begin
        ones_next = ones_reg + 1'b1;
      end
    end
  end

  // State registers.
  // Reset asserts asynchronously and drops any capture that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg     <= 1'b0;
      sel_reg   <= 2'b00;
      vld_reg   <= 1'b0;
      total_reg <= '0;
      ones_reg  <= '0;
    end else begin
      y_reg     <= y_next;
      sel_reg   <= sel_next;
      vld_reg   <= vld_next;
      total_reg <= total_next;
      ones_reg  <= ones_next;
    end
  end

  assign y_q       = y_reg;
  assign sel_q     = sel_reg;
  assign y_vld     = vld_reg;
  assign cnt_total = total_reg;
  assign cnt_ones  = ones_reg;

endmodule

// File: tb/tb_q2a_mux.sv
// Testbench for q2a_mux.
// Two instances share every input: a wide one (CNT_W=8) and a narrow one
// (CNT_W=2) that exercises saturation. Expected values come from a
// behavioural model: an arithmetic bit pick plus unbounded capture counts
// that are clipped to the counter range when compared.
module tb_q2a_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [3:0] number;
  logic [1:0] selection;

  logic       y_a, yq_a, vld_a;
  logic [1:0] selq_a;
  logic [7:0] tot_a, ones_a;
  logic       y_b, yq_b, vld_b;
  logic [1:0] selq_b;
  logic [1:0] tot_b, ones_b;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit       m_yq;
  bit [1:0] m_sel;
  bit       m_vld;
  int       n_total;
  int       n_ones;

  always #5 clk = ~clk;

  q2a_mux #(.CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .number(number), .selection(selection), .Y(y_a),
    .en(en), .clr(clr), .y_q(yq_a), .sel_q(selq_a), .y_vld(vld_a),
    .cnt_total(tot_a), .cnt_ones(ones_a)
  );

  q2a_mux #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .number(number), .selection(selection), .Y(y_b),
    .en(en), .clr(clr), .y_q(yq_b), .sel_q(selq_b), .y_vld(vld_b),
    .cnt_total(tot_b), .cnt_ones(ones_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_pick(input logic [3:0] n, input logic [1:0] s);
    return bit'((int'(n) >> int'(s)) & 1);
  endfunction

  function automatic int sat(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic model_reset();
    m_yq    = 1'b0;
    m_sel   = 2'b00;
    m_vld   = 1'b0;
    n_total = 0;
    n_ones  = 0;
  endtask

  task automatic check_y(input string ctx);
    check({ctx, " Y8"}, 32'(y_a), 32'(ref_pick(number, selection)));
    check({ctx, " Y2"}, 32'(y_b), 32'(ref_pick(number, selection)));
  endtask

  task automatic check_regs(input string ctx);
    check({ctx, " y_q"},       32'(yq_a),   32'(m_yq));
    check({ctx, " sel_q"},     32'(selq_a), 32'(m_sel));
    check({ctx, " y_vld"},     32'(vld_a),  32'(m_vld));
    check({ctx, " total8"},    32'(tot_a),  32'(sat(n_total, 8)));
    check({ctx, " ones8"},     32'(ones_a), 32'(sat(n_ones, 8)));
    check({ctx, " y_q2"},      32'(yq_b),   32'(m_yq));
    check({ctx, " sel_q2"},    32'(selq_b), 32'(m_sel));
    check({ctx, " y_vld2"},    32'(vld_b),  32'(m_vld));
    check({ctx, " total2"},    32'(tot_b),  32'(sat(n_total, 2)));
    check({ctx, " ones2"},     32'(ones_b), 32'(sat(n_ones, 2)));
    check({ctx, " invariant"}, 32'(ones_a <= tot_a && ones_b <= tot_b), 32'd1);
  endtask

  // One clock edge: update the model from the inputs present at the edge,
  // then compare all outputs 1 time unit later.
  task automatic cycle(input string ctx);
    @(posedge clk);
    if (en) begin
      m_yq  = ref_pick(number, selection);
      m_sel = selection;
    end
    m_vld = en;
    if (clr) begin
      n_total = 0;
      n_ones  = 0;
    end else if (en) begin
      n_total++;
      n_ones += int'(ref_pick(number, selection));
    end
    #1;
    $display("%s: number=%b sel=%0d en=%0b clr=%0b -> Y=%0b y_q=%0b sel_q=%0d vld=%0b tot=%0d/%0d ones=%0d/%0d",
             ctx, number, selection, en, clr, y_a, yq_a, selq_a, vld_a, tot_a, tot_b, ones_a, ones_b);
    check_regs(ctx);
    check_y(ctx);
  endtask

  // Drive number so that the currently selected bit equals want.
  task automatic drive_bit(input bit want);
    logic [3:0] n;
    n = 4'($urandom_range(0, 15));
    n[selection] = want;
    number = n;
  endtask

  initial begin
    bit seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n     = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    number    = 4'h0;
    selection = 2'd0;
    model_reset();

    // Reset state: all registered outputs hold at 0 while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");

    // Exhaustive mux sweep while reset is held; Y must stay live.
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < 4; s++) begin
        number    = 4'(n);
        selection = 2'(s);
        #1;
        check_y($sformatf("sweep n=%0h s=%0d", n, s));
      end
    end
    check_regs("reset after sweep");

    // Release reset between edges.
    // A capture is requested on the very first edge after release.
    @(negedge clk);
    rst_n     = 1'b1;
    number    = 4'b0100;
    selection = 2'd2;
    en        = 1'b1;
    cycle("capture");
    en = 1'b0;
    cycle("capture hold");

    // Counting: clear, then five captures with Y = 1,0,1,1,0.
    clr = 1'b1;
    cycle("clear");
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en        = 1'b1;
      selection = 2'($urandom_range(0, 3));
      drive_bit(seq[i]);
      cycle($sformatf("count %0d", i));
    end
    check("count total", 32'(tot_a), 32'd5);
    check("count ones", 32'(ones_a), 32'd3);

    // clr together with en: the counters clear and the capture still lands.
    clr       = 1'b1;
    selection = 2'd1;
    number    = 4'b0010;
    cycle("clr+en");
    check("clr+en y_q", 32'(yq_a), 32'd1);
    clr = 1'b0;

    // Saturation: six captures with Y=1 after a clear.
    en  = 1'b0;
    clr = 1'b1;
    cycle("sat clear");
    clr = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      selection = 2'($urandom_range(0, 3));
      drive_bit(1'b1);
      cycle($sformatf("sat %0d", i));
    end
    check("sat total2", 32'(tot_b), 32'd3);
    check("sat ones2", 32'(ones_b), 32'd3);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      number    = 4'($urandom_range(0, 15));
      selection = 2'($urandom_range(0, 3));
      en        = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 31) == 0);
      cycle($sformatf("rand %0d", i));
    end
    clr = 1'b0;

    // Asynchronous reset mid-cycle with a capture pending.
    en     = 1'b1;
    number = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("async reset");
    @(posedge clk);
    #1;
    check_regs("reset held");
    for (int i = 0; i < 12; i++) begin
      number    = 4'($urandom_range(0, 15));
      selection = 2'($urandom_range(0, 3));
      #1;
      check_y($sformatf("reset mux %0d", i));
    end

    // Release reset and resume normal captures.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      number    = 4'($urandom_range(0, 15));
      selection = 2'($urandom_range(0, 3));
      cycle($sformatf("post reset %0d", i));
    end
    en = 1'b0;
    cycle("idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
